// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and state encoding for the round-robin arbiter
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter4_if.sv
// rtl/rr_arbiter4_if.sv - request/grant bundle between requesters and the arbiter
interface rr_arbiter4_if
    import arb_pkg::*;
();

    logic [NUM_REQ-1:0] req;
    logic               done;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;
    logic               timeout;

    // Requester side: raises requests and the release strobe, observes the grant.
    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );

endinterface

// File: rtl/decoder2to4.sv
// rtl/decoder2to4.sv - 2-bit index to 4-bit one-hot decoder
module decoder2to4 (
    input  logic [1:0] idx_i,
    output logic [3:0] onehot_o
);

    // Pure decode; exactly one output bit set for every index.
    always_comb begin
        onehot_o = 4'b0000;
        onehot_o[idx_i] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-requester round-robin arbiter with hold-time limit
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic         clk,
    input  logic         rst,
    rr_arbiter4_if.slave bus
);

    // Last cycle index an owner may still hold the grant; only meaningful when HOLD_MAX != 0.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

    arb_state_e          state_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic                valid_q;
    logic                timeout_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [IDX_W-1:0]    start_idx;
    logic [IDX_W-1:0]    cand_idx;
    logic [IDX_W-1:0]    winner_d;
    logic                found_d;
    logic [NUM_REQ-1:0]  winner_onehot;
    logic                rel_done;
    logic                rel_withdraw;
    logic                rel_hold;
    logic                release_d;

    // Search starts one past the last owner and wraps, so the previous owner is checked last.
    always_comb begin
        start_idx = idx_q + IDX_W'(1);
        cand_idx  = start_idx;
        winner_d  = start_idx;
        found_d   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_idx = start_idx + IDX_W'(i);
            if (!found_d && bus.req[cand_idx]) begin
                found_d  = 1'b1;
                winner_d = cand_idx;
            end
        end
    end

    decoder2to4 u_dec (
        .idx_i    (winner_d),
        .onehot_o (winner_onehot)
    );

    // Release causes while granted; timeout only reports when it is the sole cause.
    always_comb begin
        rel_done     = bus.done;
        rel_withdraw = !bus.req[idx_q];
        rel_hold     = (HOLD_MAX != 0) && (cnt_q == HOLD_LAST);
        release_d    = rel_done || rel_withdraw || rel_hold;
    end

    // Grant FSM: idle search, hold until release, one idle cycle of turnaround after every release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            idx_q     <= 2'b11;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (found_d) begin
                        state_q <= ST_GRANT;
                        gnt_q   <= winner_onehot;
                        idx_q   <= winner_d;
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                ST_GRANT: begin
                    if (release_d) begin
                        state_q   <= ST_IDLE;
                        gnt_q     <= '0;
                        valid_q   <= 1'b0;
                        timeout_q <= rel_hold && !rel_done && !rel_withdraw;
                    end else if (cnt_q != CNT_SAT) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb/tb_rr_arbiter4.sv - directed self-checking bench for rr_arbiter4
module tb_rr_arbiter4;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    rr_arbiter4_if bus ();

    rr_arbiter4 #(
        .HOLD_MAX (15),
        .CNT_W    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 4'b1111;
        bus.done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=0000", bus.gnt); end
        total++; if (bus.gnt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.gnt_valid); end
        total++; if (bus.gnt_idx !== 2'd3) begin bad++; $display("FAIL reset_idx got=%0d want=3", bus.gnt_idx); end
        total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", bus.timeout); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL reset_first_gnt got=%b want=0001", bus.gnt); end
        total++; if (bus.gnt_valid !== 1'b1) begin bad++; $display("FAIL reset_first_valid got=%b want=1", bus.gnt_valid); end
    endtask

    // Entered with owner 0 in its first grant cycle and req=1111.
    task automatic test_rotation();
        logic [3:0] exp;
        for (int g = 0; g < 4; g++) begin
            exp = 4'b0001 << g;
            for (int c = 1; c <= 3; c++) begin
                total++; if (bus.gnt !== exp) begin bad++; $display("FAIL rot_gnt owner=%0d cyc=%0d got=%b want=%b", g, c, bus.gnt, exp); end
                bus.done = (c == 3);
                @(negedge clk);
            end
            bus.done = 1'b0;
            total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL rot_turnaround owner=%0d got=%b want=0000", g, bus.gnt); end
            total++; if (bus.gnt_idx !== 2'(g)) begin bad++; $display("FAIL rot_idx got=%0d want=%0d", bus.gnt_idx, g); end
            @(negedge clk);
        end
        total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL rot_wrap got=%b want=0001", bus.gnt); end
    endtask

    task automatic test_withdraw();
        bus.req = 4'b0000;
        @(negedge clk);
        total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL wd_release0 got=%b want=0000", bus.gnt); end
        bus.req = 4'b0100;
        @(negedge clk);
        total++; if (bus.gnt !== 4'b0100) begin bad++; $display("FAIL wd_gnt2 got=%b want=0100", bus.gnt); end
        bus.req = 4'b0011;
        @(negedge clk);
        total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL wd_drop got=%b want=0000", bus.gnt); end
        total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL wd_timeout got=%b want=0", bus.timeout); end
        total++; if (bus.gnt_idx !== 2'd2) begin bad++; $display("FAIL wd_idx got=%0d want=2", bus.gnt_idx); end
        @(negedge clk);
        total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL wd_wrap got=%b want=0001", bus.gnt); end
    endtask

    task automatic test_timeout();
        int n;
        bus.req = 4'b0000;
        @(negedge clk);
        bus.req = 4'b0010;
        @(negedge clk);
        n = 0;
        while (bus.gnt === 4'b0010 && n < 40) begin
            total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL to_early_pulse cyc=%0d got=%b want=0", n, bus.timeout); end
            n++;
            @(negedge clk);
        end
        total++; if (n != 15) begin bad++; $display("FAIL to_hold_len got=%0d want=15", n); end
        total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL to_gnt got=%b want=0000", bus.gnt); end
        total++; if (bus.timeout !== 1'b1) begin bad++; $display("FAIL to_pulse got=%b want=1", bus.timeout); end
        @(negedge clk);
        total++; if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL to_regrant got=%b want=0010", bus.gnt); end
        total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL to_pulse_len got=%b want=0", bus.timeout); end
    endtask

    // Entered with owner 1 in its first grant cycle.
    task automatic test_simultaneous();
        for (int c = 1; c < 15; c++) @(negedge clk);
        total++; if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL sim_still_held got=%b want=0010", bus.gnt); end
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
        total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL sim_release got=%b want=0000", bus.gnt); end
        total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL sim_timeout got=%b want=0", bus.timeout); end
        @(negedge clk);
        total++; if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL sim_regrant got=%b want=0010", bus.gnt); end
        rst = 1'b1;
        bus.done = 1'b1;
        @(negedge clk);
        total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL rst_mid_gnt got=%b want=0000", bus.gnt); end
        total++; if (bus.gnt_idx !== 2'd3) begin bad++; $display("FAIL rst_mid_idx got=%0d want=3", bus.gnt_idx); end
        total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL rst_mid_timeout got=%b want=0", bus.timeout); end
        total++; if (bus.gnt_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", bus.gnt_valid); end
        rst = 1'b0;
        bus.done = 1'b0;
        bus.req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_idle_hold();
        bus.req = 4'b0010;
        @(negedge clk);
        total++; if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL idle_gnt1 got=%b want=0010", bus.gnt); end
        bus.req = 4'b0000;
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            bus.done = (c == 4);
            total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL idle_gnt cyc=%0d got=%b want=0000", c, bus.gnt); end
            total++; if (bus.gnt_idx !== 2'd1) begin bad++; $display("FAIL idle_idx cyc=%0d got=%0d want=1", c, bus.gnt_idx); end
            total++; if (bus.gnt_valid !== 1'b0) begin bad++; $display("FAIL idle_valid cyc=%0d got=%b want=0", c, bus.gnt_valid); end
            @(negedge clk);
        end
        bus.done = 1'b0;
        bus.req = 4'b0011;
        @(negedge clk);
        total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL idle_wrap got=%b want=0001", bus.gnt); end
        total++; if (bus.gnt_idx !== 2'd0) begin bad++; $display("FAIL idle_wrap_idx got=%0d want=0", bus.gnt_idx); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        bus.req = 4'b0000;
        bus.done = 1'b0;
        @(negedge clk);
        test_reset();
        test_rotation();
        test_withdraw();
        test_timeout();
        test_simultaneous();
        test_idle_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
